// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and helpers for the LED blink generator
// Contents:
//   led_state_t  blink FSM state encoding
//   max_one()    phase-length load helper; a programmed 0 loads as 1
package led_pkg;

  typedef enum logic [1:0] {
    LED_IDLE = 2'd0,
    LED_ON   = 2'd1,
    LED_OFF  = 2'd2
  } led_state_t;

  // Phase lengths of 0 would never expire on a down-counter, so they are
  // promoted to the shortest meaningful phase of one tick.
  function automatic logic [31:0] max_one(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/led_blink_gen_if.sv
// rtl/led_blink_gen_if.sv - blink train request handshake bundle
// Signals:
//   iReqVd    requester -> generator  request valid, held until accepted
//   oReqRdy   generator -> requester  ready, high only while idle
//   iOnTime   requester -> generator  ON phase length in ticks
//   iOffTime  requester -> generator  OFF phase length in ticks
//   iRepeat   requester -> generator  number of ON pulses
interface led_blink_gen_if #(
  parameter int pTimeW = 8,
  parameter int pRptW  = 4
);

  logic              iReqVd;
  logic              oReqRdy;
  logic [pTimeW-1:0] iOnTime;
  logic [pTimeW-1:0] iOffTime;
  logic [pRptW-1:0]  iRepeat;

  modport master (
    output iReqVd, iOnTime, iOffTime, iRepeat,
    input  oReqRdy
  );

  modport slave (
    input  iReqVd, iOnTime, iOffTime, iRepeat,
    output oReqRdy
  );

endinterface

// File: rtl/led_phase_timer.sv
// rtl/led_phase_timer.sv - tick-driven phase down-counter with expire flag
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset, clears the count
//   cke       in   tick strobe; each strobe decrements a non-zero count
//   load      in   load load_val (wins over clear and decrement)
//   load_val  in   phase length, already promoted to at least 1
//   clear     in   drop the count to 0 (abort path)
//   expire    out  high in the cycle whose tick consumes the last count
module led_phase_timer #(
  parameter int pTimeW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cke,
  input  logic              load,
  input  logic [pTimeW-1:0] load_val,
  input  logic              clear,
  output logic              expire
);

  logic [pTimeW-1:0] cnt_q;
  logic [pTimeW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clear) begin
      cnt_d = '0;
    end else if (cke && (cnt_q != '0)) begin
      cnt_d = cnt_q - pTimeW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The tick seen while the count sits at 1 is the last tick of the phase;
  // the FSM acts on it at the same edge, so an N-tick phase spans N strobes.
  assign expire = cke && (cnt_q == pTimeW'(1));

endmodule

// File: rtl/led_blink_gen.sv
// rtl/led_blink_gen.sv - user LED blink train generator
// Ports:
//   iSysClk   in   system clock
//   iSysRst   in   synchronous active-high reset
//   iCke      in   1-cycle tick strobe timing every phase
//   req       if   request handshake (slave side), see led_blink_gen_if
//   iAbort    in   cancel a running train, no tick needed
//   oUserLed  out  LED drive, pIdleLevel when not blinking
//   oBusy     out  high while a train is running
//   oDone     out  1-cycle pulse on normal completion (or empty train)
module led_blink_gen
  import led_pkg::*;
#(
  parameter int   pTimeW     = 8,
  parameter int   pRptW      = 4,
  parameter logic pIdleLevel = 1'b0
) (
  input  logic            iSysClk,
  input  logic            iSysRst,
  input  logic            iCke,
  led_blink_gen_if.slave  req,
  input  logic            iAbort,
  output logic            oUserLed,
  output logic            oBusy,
  output logic            oDone
);

  localparam logic LedActive = ~pIdleLevel;

  led_state_t        state_q,    state_d;
  logic              led_q,      led_d;
  logic              done_q,     done_d;
  logic [pRptW-1:0]  rpt_q,      rpt_d;
  logic [pTimeW-1:0] on_time_q,  on_time_d;
  logic [pTimeW-1:0] off_time_q, off_time_d;

  logic              tmr_load;
  logic [pTimeW-1:0] tmr_val;
  logic              tmr_clear;
  logic              tmr_expire;

  led_phase_timer #(
    .pTimeW (pTimeW)
  ) u_timer (
    .clk      (iSysClk),
    .rst      (iSysRst),
    .cke      (iCke),
    .load     (tmr_load),
    .load_val (tmr_val),
    .clear    (tmr_clear),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    done_d     = 1'b0;
    rpt_d      = rpt_q;
    on_time_d  = on_time_q;
    off_time_d = off_time_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_clear  = 1'b0;

    case (state_q)
      LED_IDLE: begin
        // Abort is meaningless here; a request offered with it still goes in.
        if (req.iReqVd) begin
          on_time_d  = req.iOnTime;
          off_time_d = req.iOffTime;
          if (req.iRepeat == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = LED_ON;
            led_d    = LedActive;
            rpt_d    = req.iRepeat;
            tmr_load = 1'b1;
            tmr_val  = pTimeW'(max_one(32'(req.iOnTime)));
          end
        end
      end

      LED_ON: begin
        if (iAbort) begin
          state_d   = LED_IDLE;
          led_d     = pIdleLevel;
          rpt_d     = '0;
          tmr_clear = 1'b1;
        end else if (tmr_expire) begin
          if (rpt_q > pRptW'(1)) begin
            state_d  = LED_OFF;
            led_d    = pIdleLevel;
            rpt_d    = rpt_q - pRptW'(1);
            tmr_load = 1'b1;
            tmr_val  = pTimeW'(max_one(32'(off_time_q)));
          end else begin
            // Last pulse: return straight to idle with no trailing OFF.
            state_d = LED_IDLE;
            led_d   = pIdleLevel;
            rpt_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      LED_OFF: begin
        if (iAbort) begin
          state_d   = LED_IDLE;
          led_d     = pIdleLevel;
          rpt_d     = '0;
          tmr_clear = 1'b1;
        end else if (tmr_expire) begin
          state_d  = LED_ON;
          led_d    = LedActive;
          tmr_load = 1'b1;
          tmr_val  = pTimeW'(max_one(32'(on_time_q)));
        end
      end

      default: begin
        state_d   = LED_IDLE;
        led_d     = pIdleLevel;
        rpt_d     = '0;
        tmr_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      state_q    <= LED_IDLE;
      led_q      <= pIdleLevel;
      done_q     <= 1'b0;
      rpt_q      <= '0;
      on_time_q  <= '0;
      off_time_q <= '0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      done_q     <= done_d;
      rpt_q      <= rpt_d;
      on_time_q  <= on_time_d;
      off_time_q <= off_time_d;
    end
  end

  assign oUserLed    = led_q;
  assign oDone       = done_q;
  assign oBusy       = (state_q != LED_IDLE);
  assign req.oReqRdy = (state_q == LED_IDLE);

endmodule
